// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package fifo_stream_pkg;

    localparam int unsigned FIFO_WIDTH_DEFAULT = 16;
    localparam int unsigned OCC_MAX            = 2;

    typedef logic [1:0]                    occ_t;
    typedef logic [FIFO_WIDTH_DEFAULT-1:0] word_t;

    // Words held or owed to the buffer after this cycle's pop.
    function automatic logic [2:0] level_after(input occ_t occ, input logic inflight,
                                               input logic pop);
        return 3'(occ) + 3'(inflight) - 3'(pop);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// Two-entry in-order output buffer: head register feeds the stream, tail holds the spare.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] tail_d;
    occ_t             occ_q;
    occ_t             occ_d;

    // Push never targets a full buffer and pop never targets an empty one.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = push_data;
                    else               tail_d = push_data;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_d = push_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pulls words from a one-cycle-latency FIFO read port and presents them as a valid/ready stream.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  underflow_err
);

    occ_t                 occ;
    logic                 inflight_q;
    logic                 pop;
    logic                 push;
    logic [2:0]           level;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 err_q;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign push    = inflight_q && !flush;
    assign level   = level_after(occ, inflight_q, pop);

    // Same-cycle pop frees a slot, so m_ready feeds the read request directly.
    assign fifo_rd_en = rst_n && !fifo_empty && !flush && (level < 3'(OCC_MAX));

    stream_skid_buf #(
        .WIDTH(FIFO_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push),
        .push_data(fifo_data_out),
        .pop      (pop),
        .occ      (occ),
        .head     (m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (pop)                         count_q <= count_q + CNT_WIDTH'(1);
            if (inflight_q && fifo_underflow) err_q  <= 1'b1;
        end
    end

    assign word_count    = count_q;
    assign underflow_err = err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized checks of fifo_rd_stream against a queue-based reference model.
module tb_fifo_rd_stream;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_underflow;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [CW-1:0] word_count;
    logic          underflow_err;

    always #5 clk = ~clk;

    fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_underflow(fifo_underflow),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .word_count    (word_count),
        .underflow_err (underflow_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // FIFO model
    logic [W-1:0] fq[$];
    logic         uf_pulse = 1'b0;
    logic         force_uf = 1'b0;

    // Reference model of the adapter
    logic [W-1:0] mq[$];
    logic         pend = 1'b0;
    int           cnt  = 0;
    logic         uerr = 1'b0;

    // Observation history
    bit           rd_hist[$];
    bit           val_hist[$];
    logic [W-1:0] got[$];
    int           rd_on_empty = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_fifo(input logic [W-1:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    function automatic int first_idx(input bit use_val, input int from);
        for (int i = from; i < rd_hist.size(); i++)
            if ((use_val ? val_hist[i] : rd_hist[i])) return i;
        return -1;
    endfunction

    function automatic int count_high(input bit use_val, input int from, input int n);
        int c = 0;
        for (int i = from; i < from + n && i < rd_hist.size(); i++)
            if ((use_val ? val_hist[i] : rd_hist[i])) c++;
        return c;
    endfunction

    // One clock cycle: check outputs against the model, then advance model and FIFO.
    task automatic step();
        logic pop;
        logic exp_rd;
        logic rd_s;
        int   lvl;
        fifo_underflow = uf_pulse | force_uf;
        #1;
        pop    = (mq.size() != 0) && m_ready;
        lvl    = mq.size() + int'(pend) - int'(pop);
        exp_rd = !fifo_empty && !flush && (lvl < 2);
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
        chk("word_count", 32'(word_count), 32'(cnt % 16));
        chk("underflow_err", 32'(underflow_err), 32'(uerr));
        rd_s = fifo_rd_en;
        rd_hist.push_back(fifo_rd_en);
        val_hist.push_back(m_valid);
        if (fifo_rd_en && fifo_empty) rd_on_empty++;
        if (m_valid && m_ready) got.push_back(m_data);
        @(posedge clk);
        #1;
        if (pend && fifo_underflow) uerr = 1'b1;
        if (pop) begin
            void'(mq.pop_front());
            cnt++;
        end
        if (pend && !flush) mq.push_back(fifo_data_out);
        if (flush) mq.delete();
        pend     = exp_rd;
        uf_pulse = 1'b0;
        if (rd_s) begin
            if (fq.size() != 0) fifo_data_out = fq.pop_front();
            else                uf_pulse = 1'b1;
        end
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_underflow_err", 32'(underflow_err), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        mq.delete();
        pend     = 1'b0;
        cnt      = 0;
        uerr     = 1'b0;
        uf_pulse = 1'b0;
        force_uf = 1'b0;
        flush    = 1'b0;
        fifo_underflow = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int s;
        int g0;
        int fr;
        int fv;
        rst_n          = 1'b1;
        flush          = 1'b0;
        m_ready        = 1'b0;
        fifo_empty     = 1'b1;
        fifo_data_out  = '0;
        fifo_underflow = 1'b0;
        @(negedge clk);
        do_reset();

        // Streaming 1..8 with the consumer always ready
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_fifo(W'(i));
        s  = rd_hist.size();
        g0 = got.size();
        repeat (14) step();
        fr = first_idx(1'b0, s);
        chk("stream_first_rd", 32'(fr - s), 32'd0);
        chk("stream_valid_run", 32'(count_high(1'b1, fr + 2, 8)), 32'd8);
        chk("stream_count", 32'(got.size() - g0), 32'd8);
        for (int i = 0; i < 8 && g0 + i < got.size(); i++)
            chk("stream_data", 32'(got[g0 + i]), 32'(i + 1));
        chk("stream_word_count", 32'(word_count), 32'd8);

        // Backpressure: 5 words, consumer stalled for 10 cycles
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_fifo(W'(i));
        s = rd_hist.size();
        repeat (10) step();
        chk("bp_rd_pulses", 32'(count_high(1'b0, s, 10)), 32'd2);
        chk("bp_head_held", 32'(m_data), 32'h0001);
        m_ready = 1'b1;
        s  = rd_hist.size();
        g0 = got.size();
        repeat (8) step();
        chk("bp_resume_run", 32'(count_high(1'b1, s, 5)), 32'd5);
        chk("bp_resume_count", 32'(got.size() - g0), 32'd5);
        for (int i = 0; i < 5 && g0 + i < got.size(); i++)
            chk("bp_resume_data", 32'(got[g0 + i]), 32'(i + 1));

        // Reset with a full buffer, then latency of the first word after release
        m_ready = 1'b0;
        push_fifo(16'h0031);
        push_fifo(16'h0032);
        push_fifo(16'h0033);
        repeat (3) step();
        chk("pre_reset_full", 32'(m_valid), 32'd1);
        do_reset();
        m_ready = 1'b1;
        s  = rd_hist.size();
        g0 = got.size();
        repeat (6) step();
        fr = first_idx(1'b0, s);
        fv = first_idx(1'b1, s);
        chk("post_reset_latency", 32'(fv - fr), 32'd2);
        chk("post_reset_word", 32'(got.size() > g0 ? got[g0] : '0), 32'h0033);

        // Flush in the cycle the first read's data arrives
        push_fifo(16'h00a0);
        push_fifo(16'h00a1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_drop_valid", 32'(m_valid), 32'd0);
        s  = rd_hist.size();
        g0 = got.size();
        repeat (5) step();
        fr = first_idx(1'b0, s);
        fv = first_idx(1'b1, s);
        chk("flush_next_rd", 32'(fr - s), 32'd0);
        chk("flush_next_latency", 32'(fv - fr), 32'd2);
        chk("flush_next_count", 32'(got.size() - g0), 32'd1);
        chk("flush_next_word", 32'(got.size() > g0 ? got[g0] : '0), 32'h00a1);

        // Underflow flagged on a response cycle, sticky through flush
        push_fifo(16'h0055);
        step();
        force_uf = 1'b1;
        step();
        force_uf = 1'b0;
        chk("uf_set", 32'(underflow_err), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("uf_sticky_flush", 32'(underflow_err), 32'd1);
        do_reset();

        // Counter wrap with a 4-bit counter
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_fifo(W'(16'h0100 + i));
        repeat (22) step();
        chk("wrap_word_count", 32'(word_count), 32'd1);

        // Randomized traffic, backpressure, flushes and underflow strobes
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 8) push_fifo(W'($urandom));
            m_ready  = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            force_uf = ($urandom_range(0, 24) == 0);
            step();
        end
        flush    = 1'b0;
        force_uf = 1'b0;
        step();

        chk("no_read_when_empty", 32'(rd_on_empty), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
